// File: rtl/sram_pkg.sv
// Shared widths, FSM encoding and port identifiers for the SRAM arbiter slice.
package sram_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win last time goes.
module rr_arb2
    import sram_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = a_req | b_req;
        grant_id    = PORT_A;
        if (a_req && b_req) begin
            grant_id = ~last;
        end else if (b_req) begin
            grant_id = PORT_B;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_driver between two requesters: grants one word op at a time,
// sequences the driver start/ready handshake and returns read data to the winner.
module sram_arbiter #(
    parameter int unsigned ADDR_W = sram_pkg::ADDR_W,
    parameter int unsigned DATA_W = sram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              drv_ready,
    input  logic [DATA_W-1:0] drv_data_out,
    output logic              drv_start,
    output logic              drv_re,
    output logic [ADDR_W-1:0] drv_address,
    output logic [DATA_W-1:0] drv_data_in,
    output logic              busy
);

    import sram_pkg::*;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              grant_valid, grant_id;
    logic              drv_start_d, drv_re_d, busy_d;
    logic [ADDR_W-1:0] drv_address_d;
    logic [DATA_W-1:0] drv_data_in_d;
    logic              a_ack_d, b_ack_d, a_done_d, b_done_d;
    logic [DATA_W-1:0] a_rdata_d, b_rdata_d;

    rr_arb2 u_rr_arb2 (
        .a_req       (a_req),
        .b_req       (b_req),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // last_q doubles as the owner of the in-flight op: it is written on every grant.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        drv_start_d   = 1'b0;
        drv_re_d      = drv_re;
        drv_address_d = drv_address;
        drv_data_in_d = drv_data_in;
        a_ack_d       = 1'b0;
        b_ack_d       = 1'b0;
        a_done_d      = 1'b0;
        b_done_d      = 1'b0;
        a_rdata_d     = a_rdata;
        b_rdata_d     = b_rdata;

        case (state_q)
            IDLE: begin
                if (drv_ready && grant_valid) begin
                    state_d     = WAIT_LOW;
                    last_d      = grant_id;
                    drv_start_d = 1'b1;
                    if (grant_id == PORT_A) begin
                        a_ack_d       = 1'b1;
                        drv_re_d      = ~a_we;
                        drv_address_d = a_addr;
                        drv_data_in_d = a_wdata;
                    end else begin
                        b_ack_d       = 1'b1;
                        drv_re_d      = ~b_we;
                        drv_address_d = b_addr;
                        drv_data_in_d = b_wdata;
                    end
                end
            end
            WAIT_LOW: begin
                if (!drv_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (drv_ready) begin
                    state_d = IDLE;
                    if (last_q == PORT_A) begin
                        a_done_d = 1'b1;
                        if (drv_re) a_rdata_d = drv_data_out;
                    end else begin
                        b_done_d = 1'b1;
                        if (drv_re) b_rdata_d = drv_data_out;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            last_q      <= PORT_B;
            drv_start   <= 1'b0;
            drv_re      <= 1'b0;
            drv_address <= '0;
            drv_data_in <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            drv_start   <= drv_start_d;
            drv_re      <= drv_re_d;
            drv_address <= drv_address_d;
            drv_data_in <= drv_data_in_d;
            a_ack       <= a_ack_d;
            b_ack       <= b_ack_d;
            a_done      <= a_done_d;
            b_done      <= b_done_d;
            a_rdata     <= a_rdata_d;
            b_rdata     <= b_rdata_d;
            busy        <= busy_d;
        end
    end

endmodule
